// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: turns one cache line read/write into a burst of
// BURST_W-bit beats on the physical memory port, one beat per resp_i.
// Optional build macro CACHELINE_ADAPTOR_POSTED_WRITE_EN: writes complete to
// the cache as soon as the line is buffered, and the burst drains afterwards.
module cacheline_adaptor #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64,
  parameter int ADDR_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  address_i,
  input  logic               read_i,
  input  logic               write_i,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  output logic               resp_o,
  output logic [ADDR_W-1:0]  address_o,
  output logic               read_o,
  output logic               write_o,
  output logic [BURST_W-1:0] burst_o,
  input  logic [BURST_W-1:0] burst_i,
  input  logic               resp_i
);

  localparam int BEATS = LINE_W / BURST_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  // Byte-offset bits inside a line; forced to zero on the memory address.
  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] RD_BURST = 2'd1;
  localparam logic [1:0] WR_BURST = 2'd2;
  localparam logic [1:0] DONE     = 2'd3;

  logic [1:0]        state;
  logic [CNT_W-1:0]  beat_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] line_q;
  logic [LINE_W-1:0] wr_buf;

  // The low address bits are dropped by line alignment.
  logic unused_addr_bits;
  assign unused_addr_bits = ^address_i[OFF_W-1:0];

  // Transaction FSM: accept in IDLE (write has priority), count acked beats.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      beat_cnt <= '0;
      addr_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (write_i) begin
            state    <= WR_BURST;
            beat_cnt <= '0;
            addr_q   <= {address_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          end else if (read_i) begin
            state    <= RD_BURST;
            beat_cnt <= '0;
            addr_q   <= {address_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          end
        end
        RD_BURST, WR_BURST: begin
          if (resp_i) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
            if (beat_cnt == LAST_BEAT) state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read line assembly: each acked read beat lands in its slot of line_q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_q <= '0;
    end else if (state == RD_BURST && resp_i) begin
      line_q[beat_cnt*BURST_W +: BURST_W] <= burst_i;
    end
  end

  // Write buffer captures the cache line when a write is accepted.
  always_ff @(posedge clk) begin
    if (state == IDLE && write_i) wr_buf <= line_i;
  end

  assign line_o    = line_q;
  assign address_o = addr_q;
  assign read_o    = (state == RD_BURST);
  assign write_o   = (state == WR_BURST);
  assign burst_o   = (state == WR_BURST) ? wr_buf[beat_cnt*BURST_W +: BURST_W]
                                         : '0;

`ifdef CACHELINE_ADAPTOR_POSTED_WRITE_EN
  logic post_pulse;
  logic txn_is_wr;

  // Early write completion: pulse right after accept, and suppress the
  // DONE pulse of the drained write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      post_pulse <= 1'b0;
      txn_is_wr  <= 1'b0;
    end else begin
      post_pulse <= (state == IDLE) && write_i;
      if (state == IDLE && (write_i || read_i)) txn_is_wr <= write_i;
    end
  end

  assign resp_o = post_pulse | ((state == DONE) & ~txn_is_wr);
`else
  assign resp_o = (state == DONE);
`endif

endmodule

// File: doc/cacheline_adaptor.md
Name: cacheline_adaptor

Overview:
- Sits directly downstream of the 2-way cache. Converts one 256-bit line read or write into a 4-beat 64-bit burst on the physical memory port.
- Cache side carries a line-aligned address, read/write strobes held until `resp_o`, and full 256-bit data.
- Memory side is a burst interface that acknowledges each 64-bit beat with `resp_i`.

Parameters:
- LINE_W, 256, cache line width in bits.
- BURST_W, 64, memory beat width in bits. LINE_W/BURST_W is the beat count (4), and must be a power of two.
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- address_i  in  ADDR_W  line address from cache.
- read_i  in  1  line read request, held until resp_o.
- write_i  in  1  line write request, held until resp_o.
- line_i  in  LINE_W  write line from cache.
- line_o  out  LINE_W  read line to cache.
- resp_o  out  1  one-cycle completion pulse to cache.
- address_o  out  ADDR_W  burst address to memory.
- read_o  out  1  burst read request.
- write_o  out  1  burst write request.
- burst_o  out  BURST_W  write beat data.
- burst_i  in  BURST_W  read beat data.
- resp_i  in  1  per-beat acknowledge from memory.

Behaviour:
- Reset (rst=0, async): state IDLE, beat counter 0. All outputs are 0: `line_o`, `resp_o`, `address_o`, `read_o`, `write_o`, `burst_o`.
- States: IDLE, RD_BURST, WR_BURST, DONE.
- IDLE:
  - Samples requests. If `write_i` is high: latch `line_i` into the write buffer, latch `address_o = {address_i[ADDR_W-1:5], 5'b0}`, counter=0, go to WR_BURST.
  - Else if `read_i` is high: latch the address the same way, counter=0, go to RD_BURST.
  - Simultaneous `read_i` and `write_i`: write wins; the read is serviced on a later IDLE visit if still held.
- RD_BURST:
  - `read_o`=1.
  - On each cycle with `resp_i`=1: `burst_i` is stored in `line_o` beat[counter] (beat k = bits [64k+63:64k]) and the counter increments.
  - On the 4th acknowledged beat go to DONE.
  - `resp_i` beats need not be consecutive; gap cycles hold the counter.
- WR_BURST:
  - `write_o`=1; `burst_o` = buffered beat[counter], stable until that beat is acknowledged.
  - On `resp_i`=1 the counter increments. On the 4th acknowledged beat go to DONE.
- DONE: `resp_o`=1 for exactly one cycle, `read_o`/`write_o`=0, then go to IDLE.
- Request/strobe rules:
  - Cache request strobes are ignored outside IDLE.
  - A request still high in the IDLE cycle after DONE starts a new transaction.
- `line_o`:
  - Registered; valid from the DONE cycle.
  - Holds its value until the next read overwrites beat 0.
  - Partially updated during a read burst; the cache must not sample it before `resp_o`.
- `address_o`: latched once per transaction; constant for the whole burst; low 5 bits always 0.
- `resp_i` while in IDLE or DONE: ignored, no state change.
- Counter: 2 bits, wraps 3→0 on the final beat.
- Latency: read with back-to-back beats → `resp_o` asserts 1 cycle after the 4th `resp_i`. Minimum request-to-`resp_o` is 6 cycles: 1 IDLE, 4 beats, 1 DONE.
- Reset mid-burst: transaction abandoned immediately, outputs return to reset values, no `resp_o` issued.

Optional Feature:
- Macro: CACHELINE_ADAPTOR_POSTED_WRITE_EN.
- With the macro:
  - A write completes to the cache early: `resp_o` pulses the cycle after IDLE latches `line_i`.
  - WR_BURST then drains the buffered line to memory in the background.
  - A new `read_i`/`write_i` is not accepted until the drain finishes and the FSM is back in IDLE.
  - Read-after-write to the same line therefore always observes memory updated.
- Without the macro: `resp_o` for a write occurs only in DONE after the 4th write beat is acknowledged, as above.

Test Plan:
- Read, consecutive beats: `address_i`=0x0000_1234, `read_i`=1; memory returns 0x11..11, 0x22..22, 0x33..33, 0x44..44 with `resp_i` high 4 cycles. Required: `address_o`=0x0000_1220 and `read_o` high throughout; `resp_o` pulses 1 cycle after the last beat; `line_o`={0x44..44,0x33..33,0x22..22,0x11..11}.
- Read with gaps: `resp_i` pattern 1,0,0,1,1,0,1. Required: same `line_o`; `resp_o` exactly one cycle after the 7th cycle; counter never advances on gap cycles.
- Write: `line_i`=0xDDDD..CCCC..BBBB..AAAA (beats A,B,C,D), `write_i`=1, memory acks each beat after 2 wait cycles. Required: `burst_o` sequence A,B,C,D, each stable until acked; `write_o` drops the cycle after the 4th ack; `resp_o` then pulses once (without macro).
- Simultaneous `read_i`=1 and `write_i`=1 in IDLE. Required: `write_o` asserted first and the write burst completes; the read starts afterwards if `read_i` is still held.
- Async reset after 2 read beats, `rst`=0 mid-cycle. Required: `read_o`, `resp_o` and `address_o` go to 0 without waiting for a clock edge. After `rst`=1, a fresh read completes normally with a counter starting at beat 0.
- With CACHELINE_ADAPTOR_POSTED_WRITE_EN: write then immediate read. Required: `resp_o` for the write 1 cycle after IDLE accept; `read_o` asserts only after the 4th write beat is acked.
